// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: a 2-entry skid buffer toward MEM plus branch resolution/redirect.
// Optional performance counters are enabled with the EX_MEM_PERF_CNT_EN macro.
module ex_mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_i,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic [3:0]            alu_op_i,
   input  logic                  is_branch_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic [DATA_WIDTH-1:0] imm_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic                  reg_write_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [2:0]            funct3_i,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [DATA_WIDTH-1:0] mem_result_o,
   output logic [DATA_WIDTH-1:0] mem_store_data_o,
   output logic [REG_ADDR_W-1:0] mem_rd_o,
   output logic                  mem_reg_write_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [2:0]            mem_funct3_o,
   output logic                  redirect_o,
   output logic [DATA_WIDTH-1:0] redirect_pc_o
`ifdef EX_MEM_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fwd_cnt_o,
   output logic [31:0]           perf_redirect_cnt_o,
   output logic [31:0]           perf_stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [DATA_WIDTH-1:0] store_data;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic [2:0]            funct3;
   } beat_t;

   state_e                state_q, state_d;
   beat_t                 main_q, main_d;
   beat_t                 skid_q, skid_d;
   beat_t                 in_beat_s;
   logic                  ex_ready_q, mem_valid_q;
   logic                  redirect_q;
   logic [DATA_WIDTH-1:0] redirect_pc_q;
   logic                  accept_s, fwd_s, consume_s, taken_s, cmp_op_s;

   assign in_beat_s = '{result:     alu_result_i,
                        store_data: rs2_data_i,
                        rd:         rd_i,
                        reg_write:  reg_write_i,
                        mem_read:   mem_read_i,
                        mem_write:  mem_write_i,
                        funct3:     funct3_i};

   // A flushed beat is never accepted, so it can neither fill an entry nor raise a redirect.
   assign accept_s  = ex_valid_i & ex_ready_q & ~flush_i;
   assign fwd_s     = accept_s & ~is_branch_i;
   assign consume_s = mem_valid_q & mem_ready_i;
   assign cmp_op_s  = (alu_op_i >= 4'b1000) && (alu_op_i <= 4'b1011);
   assign taken_s   = accept_s & is_branch_i & cmp_op_s & alu_result_i[0];

   // Next-state and entry-load logic for the skid buffer.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (fwd_s) begin
                  state_d = S_ONE;
                  main_d  = in_beat_s;
               end else begin
                  state_d = S_EMPTY;
               end
            end
            S_ONE: begin
               if (fwd_s && !consume_s) begin
                  state_d = S_FULL;
                  skid_d  = in_beat_s;
               end else if (fwd_s && consume_s) begin
                  state_d = S_ONE;
                  main_d  = in_beat_s;
               end else if (consume_s) begin
                  state_d = S_EMPTY;
               end else begin
                  state_d = S_ONE;
               end
            end
            S_FULL: begin
               if (consume_s) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = S_FULL;
               end
            end
            default: begin
               state_d = S_EMPTY;
            end
         endcase
      end
   end

   // State, entries, handshake flags and redirect registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_EMPTY;
         main_q        <= '0;
         skid_q        <= '0;
         ex_ready_q    <= 1'b1;
         mem_valid_q   <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         ex_ready_q  <= (state_d != S_FULL);
         mem_valid_q <= (state_d != S_EMPTY);
         redirect_q  <= taken_s;
         if (taken_s) begin
            redirect_pc_q <= pc_i + imm_i;
         end
      end
   end

   assign ex_ready_o       = ex_ready_q;
   assign mem_valid_o      = mem_valid_q;
   assign mem_result_o     = main_q.result;
   assign mem_store_data_o = main_q.store_data;
   assign mem_rd_o         = main_q.rd;
   assign mem_reg_write_o  = main_q.reg_write;
   assign mem_read_o       = main_q.mem_read;
   assign mem_write_o      = main_q.mem_write;
   assign mem_funct3_o     = main_q.funct3;
   assign redirect_o       = redirect_q;
   assign redirect_pc_o    = redirect_pc_q;

`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0] perf_fwd_q, perf_redirect_q, perf_stall_q;

   // Event counters; they ignore flush_i and only clear on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fwd_q      <= 32'd0;
         perf_redirect_q <= 32'd0;
         perf_stall_q    <= 32'd0;
      end else begin
         if (consume_s) begin
            perf_fwd_q <= perf_fwd_q + 32'd1;
         end
         if (taken_s) begin
            perf_redirect_q <= perf_redirect_q + 32'd1;
         end
         if (ex_valid_i && !ex_ready_q) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_fwd_cnt_o      = perf_fwd_q;
   assign perf_redirect_cnt_o = perf_redirect_q;
   assign perf_stall_cnt_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; counter checks run when EX_MEM_PERF_CNT_EN is defined.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset, flush_i, ex_valid_i, ex_ready_o;
   logic [31:0] alu_result_i, pc_i, imm_i, rs2_data_i;
   logic [3:0]  alu_op_i;
   logic        is_branch_i;
   logic [4:0]  rd_i;
   logic        reg_write_i, mem_read_i, mem_write_i;
   logic [2:0]  funct3_i;
   logic        mem_valid_o, mem_ready_i;
   logic [31:0] mem_result_o, mem_store_data_o;
   logic [4:0]  mem_rd_o;
   logic        mem_reg_write_o, mem_read_o, mem_write_o;
   logic [2:0]  mem_funct3_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0] perf_fwd_cnt_o, perf_redirect_cnt_o, perf_stall_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
      .alu_result_i(alu_result_i), .alu_op_i(alu_op_i), .is_branch_i(is_branch_i),
      .pc_i(pc_i), .imm_i(imm_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
      .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .funct3_i(funct3_i), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
      .mem_result_o(mem_result_o), .mem_store_data_o(mem_store_data_o),
      .mem_rd_o(mem_rd_o), .mem_reg_write_o(mem_reg_write_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_funct3_o(mem_funct3_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
`ifdef EX_MEM_PERF_CNT_EN
      , .perf_fwd_cnt_o(perf_fwd_cnt_o), .perf_redirect_cnt_o(perf_redirect_cnt_o),
      .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
   );

   // Advance one clock; outputs are then sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic v, input logic br, input logic [3:0] op,
                           input logic [31:0] res, input logic [31:0] pc, input logic [31:0] imm);
      ex_valid_i   = v;
      is_branch_i  = br;
      alu_op_i     = op;
      alu_result_i = res;
      pc_i         = pc;
      imm_i        = imm;
      rs2_data_i   = res ^ 32'hFFFF0000;
      rd_i         = res[4:0];
      reg_write_i  = 1'b1;
      mem_read_i   = 1'b0;
      mem_write_i  = 1'b0;
      funct3_i     = 3'd2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      flush_i = 1'b0;
      mem_ready_i = 1'b0;
      do_reset();
      total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", mem_valid_o); end
      total++; if (ex_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ex_ready_o); end
      total++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'd0) begin bad++; $display("FAIL reset_redirect got=%0b/%h exp=0/0", redirect_o, redirect_pc_o); end
      total++; if (mem_result_o !== 32'd0 || mem_reg_write_o !== 1'b0) begin bad++; $display("FAIL reset_data got=%h/%0b exp=0/0", mem_result_o, mem_reg_write_o); end
   endtask

   task automatic test_stream();
      mem_ready_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         set_beat(1'b1, 1'b0, 4'b0000, 32'(i), 32'd0, 32'd0);
         tick();
         total++; if (mem_valid_o !== 1'b1 || mem_result_o !== 32'(i)) begin bad++; $display("FAIL stream_%0d got=%0b/%h exp=1/%h", i, mem_valid_o, mem_result_o, 32'(i)); end
         total++; if (ex_ready_o !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%0b exp=1", i, ex_ready_o); end
      end
      total++; if (mem_store_data_o !== 32'hFFFF0003 || mem_rd_o !== 5'd3 || mem_funct3_o !== 3'd2) begin bad++; $display("FAIL stream_fields got=%h/%0d/%0d exp=ffff0003/3/2", mem_store_data_o, mem_rd_o, mem_funct3_o); end
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      tick();
      total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b exp=0", mem_valid_o); end
   endtask

   task automatic test_backpressure();
      mem_ready_i = 1'b0;
      set_beat(1'b1, 1'b0, 4'b0000, 32'hA, 32'd0, 32'd0);
      tick();
      set_beat(1'b1, 1'b0, 4'b0000, 32'hB, 32'd0, 32'd0);
      tick();
      total++; if (ex_ready_o !== 1'b0 || mem_result_o !== 32'hA) begin bad++; $display("FAIL bp_full got=%0b/%h exp=0/a", ex_ready_o, mem_result_o); end
      set_beat(1'b1, 1'b0, 4'b0000, 32'hC, 32'd0, 32'd0);
      tick();
      total++; if (ex_ready_o !== 1'b0 || mem_valid_o !== 1'b1 || mem_result_o !== 32'hA) begin bad++; $display("FAIL bp_hold got=%0b/%0b/%h exp=0/1/a", ex_ready_o, mem_valid_o, mem_result_o); end
      mem_ready_i = 1'b1;
      tick();
      total++; if (mem_valid_o !== 1'b1 || mem_result_o !== 32'hB || ex_ready_o !== 1'b1) begin bad++; $display("FAIL bp_second got=%0b/%h/%0b exp=1/b/1", mem_valid_o, mem_result_o, ex_ready_o); end
      tick();
      total++; if (mem_valid_o !== 1'b1 || mem_result_o !== 32'hC) begin bad++; $display("FAIL bp_third got=%0b/%h exp=1/c", mem_valid_o, mem_result_o); end
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      tick();
      total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", mem_valid_o); end
   endtask

   task automatic test_branch();
      mem_ready_i = 1'b1;
      set_beat(1'b1, 1'b1, 4'b1001, 32'd1, 32'h100, 32'hFFFFFFF0);
      tick();
      total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h000000F0) begin bad++; $display("FAIL br_taken got=%0b/%h exp=1/000000f0", redirect_o, redirect_pc_o); end
      total++; if (mem_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin bad++; $display("FAIL br_no_fwd got=%0b/%0b exp=0/1", mem_valid_o, ex_ready_o); end
      set_beat(1'b1, 1'b1, 4'b1001, 32'd0, 32'h300, 32'h4);
      tick();
      total++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h000000F0) begin bad++; $display("FAIL br_not_taken got=%0b/%h exp=0/000000f0", redirect_o, redirect_pc_o); end
      set_beat(1'b1, 1'b1, 4'b1011, 32'd1, 32'h200, 32'h8);
      tick();
      total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h208) begin bad++; $display("FAIL br_op1011 got=%0b/%h exp=1/00000208", redirect_o, redirect_pc_o); end
      set_beat(1'b1, 1'b1, 4'b1100, 32'd1, 32'h400, 32'h8);
      tick();
      total++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h208 || mem_valid_o !== 1'b0) begin bad++; $display("FAIL br_op1100 got=%0b/%h/%0b exp=0/00000208/0", redirect_o, redirect_pc_o, mem_valid_o); end
      set_beat(1'b1, 1'b1, 4'b0111, 32'd1, 32'h500, 32'h8);
      tick();
      total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL br_op0111 got=%0b exp=0", redirect_o); end
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      tick();
   endtask

   task automatic test_flush();
      mem_ready_i = 1'b0;
      set_beat(1'b1, 1'b0, 4'b0000, 32'h11, 32'd0, 32'd0);
      tick();
      set_beat(1'b1, 1'b0, 4'b0000, 32'h22, 32'd0, 32'd0);
      tick();
      set_beat(1'b1, 1'b1, 4'b1000, 32'd1, 32'h1000, 32'h10);
      flush_i = 1'b1;
      tick();
      total++; if (mem_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || redirect_o !== 1'b0) begin bad++; $display("FAIL flush_full got=%0b/%0b/%0b exp=0/1/0", mem_valid_o, ex_ready_o, redirect_o); end
      // Now ready is high, so the same taken branch would be accepted without the flush.
      tick();
      total++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h208 || mem_valid_o !== 1'b0) begin bad++; $display("FAIL flush_branch got=%0b/%h/%0b exp=0/00000208/0", redirect_o, redirect_pc_o, mem_valid_o); end
      flush_i = 1'b0;
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      mem_ready_i = 1'b1;
      tick();
      total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got=%0b exp=0", mem_valid_o); end
   endtask

   task automatic test_reset_full();
      mem_ready_i = 1'b0;
      set_beat(1'b1, 1'b0, 4'b0000, 32'h33, 32'd0, 32'd0);
      tick();
      set_beat(1'b1, 1'b1, 4'b1010, 32'd1, 32'h40, 32'h4);
      tick();
      set_beat(1'b1, 1'b0, 4'b0000, 32'h44, 32'd0, 32'd0);
      tick();
      total++; if (ex_ready_o !== 1'b0 || redirect_pc_o !== 32'h44) begin bad++; $display("FAIL rf_setup got=%0b/%h exp=0/00000044", ex_ready_o, redirect_pc_o); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (mem_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || redirect_pc_o !== 32'd0) begin bad++; $display("FAIL rf_state got=%0b/%0b/%h exp=0/1/0", mem_valid_o, ex_ready_o, redirect_pc_o); end
      total++; if (mem_result_o !== 32'd0 || mem_store_data_o !== 32'd0 || mem_rd_o !== 5'd0 || mem_funct3_o !== 3'd0) begin bad++; $display("FAIL rf_data got=%h/%h/%0d/%0d exp=0/0/0/0", mem_result_o, mem_store_data_o, mem_rd_o, mem_funct3_o); end
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      mem_ready_i = 1'b1;
      tick();
      total++; if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL rf_discard got=%0b exp=0", mem_valid_o); end
   endtask

`ifdef EX_MEM_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      mem_ready_i = 1'b0;
      set_beat(1'b1, 1'b0, 4'b0000, 32'd1, 32'd0, 32'd0);
      tick();
      set_beat(1'b1, 1'b0, 4'b0000, 32'd2, 32'd0, 32'd0);
      tick();
      set_beat(1'b1, 1'b0, 4'b0000, 32'd3, 32'd0, 32'd0);
      repeat (3) tick();
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      mem_ready_i = 1'b1;
      repeat (2) tick();
      for (int i = 3; i <= 5; i++) begin
         set_beat(1'b1, 1'b0, 4'b0000, 32'(i), 32'd0, 32'd0);
         tick();
      end
      set_beat(1'b1, 1'b1, 4'b1000, 32'd1, 32'h10, 32'h4);
      tick();
      set_beat(1'b1, 1'b1, 4'b1001, 32'd1, 32'h20, 32'h4);
      tick();
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      tick();
      total++; if (perf_fwd_cnt_o !== 32'd5) begin bad++; $display("FAIL perf_fwd got=%0d exp=5", perf_fwd_cnt_o); end
      total++; if (perf_redirect_cnt_o !== 32'd2) begin bad++; $display("FAIL perf_redirect got=%0d exp=2", perf_redirect_cnt_o); end
      total++; if (perf_stall_cnt_o !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", perf_stall_cnt_o); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      flush_i = 1'b0;
      mem_ready_i = 1'b0;
      set_beat(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
      test_reset();
      test_stream();
      test_backpressure();
      test_branch();
      test_flush();
      test_reset_full();
`ifdef EX_MEM_PERF_CNT_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
